// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives start and the operands, and the slave returns status and the result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor computing a - b - bin, LSB first.
// One full-subtractor cell is time-shared across WIDTH clocks, with a borrow flip-flop between bits.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             br_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;

    logic             accept_s;
    logic             last_bit_s;
    logic             d_s;
    logic             br_s;
    logic [WIDTH-1:0] res_s;

    assign accept_s   = ((state_r == IDLE) || (state_r == DONE)) && bus.start;
    assign last_bit_s = (cnt_r == CW'(WIDTH - 1));

    // Full-subtractor cell and the result shift, written to be legal for WIDTH == 1.
    always_comb begin
        d_s          = a_r[0] ^ b_r[0] ^ br_r;
        br_s         = (~a_r[0] & b_r[0]) | (~(a_r[0] ^ b_r[0]) & br_r);
        res_s        = res_r >> 1;
        res_s[WIDTH-1] = d_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = SHIFT;
                else          state_s = IDLE;
            end
            SHIFT: begin
                if (last_bit_s) state_s = DONE;
                else            state_s = SHIFT;
            end
            DONE: begin
                if (accept_s) state_s = SHIFT;
                else          state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Operand, borrow and counter registers, plus a result that is published only on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            br_r   <= 1'b0;
            cnt_r  <= '0;
            res_r  <= '0;
            diff_r <= '0;
            bout_r <= 1'b0;
        end else if (accept_s) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            br_r  <= bus.bin;
            cnt_r <= '0;
            res_r <= '0;
        end else if (state_r == SHIFT) begin
            a_r   <= a_r >> 1;
            b_r   <= b_r >> 1;
            br_r  <= br_s;
            cnt_r <= cnt_r + CW'(1);
            res_r <= res_s;
            if (last_bit_s) begin
                diff_r <= res_s;
                bout_r <= br_s;
            end
        end
    end

    assign bus.busy = (state_r == SHIFT);
    assign bus.done = (state_r == DONE);
    assign bus.diff = diff_r;
    assign bus.bout = bout_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: the driver queues arithmetic expectations,
// and a negedge monitor pops and checks them, including the cycle on which done occurs.
module tb_serial_subtractor;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    serial_subtractor_if #(.WIDTH(W)) bus ();
    serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // The reference model uses plain integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t e;
        int   v;
        v      = int'(a) - int'(b) - int'(bin);
        e.diff = v[W-1:0];
        e.bout = (v < 0);
        e.cyc  = 0;
        return e;
    endfunction

    // Monitor: pop one expectation per done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.busy && bus.done) chk("busy_and_done", 32'd1, 32'd0);
            if (bus.done) begin
                exp_t e;
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("diff", 32'(bus.diff), 32'(e.diff));
                    chk("bout", 32'(bus.bout), 32'(e.bout));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, output exp_t e);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.bin = bin; bus.start = 1'b1;
        @(posedge clk); #1;
        e = model(a, b, bin);
        e.cyc = cyc + W;
        sb.push_back(e);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t e;
        issue(a, b, bin, e);
        drain();
        @(negedge clk);
        chk("hold_diff", 32'(bus.diff), 32'(e.diff));
        chk("hold_bout", 32'(bus.bout), 32'(e.bout));
        chk("hold_done_low", 32'(bus.done), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   dc;
        rst = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_bout", 32'(bus.bout), 32'd0);
        @(negedge clk) rst = 1'b0;

        run_op(8'h3C, 8'h1A, 1'b0);
        run_op(8'h00, 8'h01, 1'b0);
        run_op(8'h55, 8'h55, 1'b1);
        run_op(8'hFF, 8'h00, 1'b1);

        // Asynchronous reset between edges clears the outputs without a clock edge.
        @(posedge clk); #2;
        rst = 1'b1; #1;
        chk("async_rst_diff", 32'(bus.diff), 32'd0);
        chk("async_rst_bout", 32'(bus.bout), 32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk) rst = 1'b0;

        // A start pulse during SHIFT is ignored.
        dc = done_cnt;
        issue(8'h10, 8'h01, 1'b0, e);
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'hBB;
        @(posedge clk); #1 bus.start = 1'b0;
        drain();
        repeat (12) @(negedge clk);
        chk("single_done", 32'(done_cnt - dc), 32'd1);

        // Reset in the middle of an operation aborts it, and the next operation behaves normally.
        dc = done_cnt;
        issue(8'h80, 8'h01, 1'b0, e);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1; #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_diff", 32'(bus.diff), 32'd0);
        chk("midrst_bout", 32'(bus.bout), 32'd0);
        sb.delete();
        @(negedge clk) rst = 1'b0;
        chk("midrst_no_done", 32'(done_cnt - dc), 32'd0);
        run_op(8'h05, 8'h07, 1'b0);

        // Back-to-back: start is held high and the operands change during DONE.
        issue(8'h09, 8'h04, 1'b0, e);
        bus.start = 1'b1;
        for (int i = 0; i < 20 && !bus.done; i++) @(negedge clk);
        bus.a = 8'h02; bus.b = 8'h03; bus.bin = 1'b0;
        @(posedge clk); #1;
        e = model(8'h02, 8'h03, 1'b0);
        e.cyc = cyc + W;
        sb.push_back(e);
        bus.start = 1'b0;
        drain();

        // Random operands.
        for (int i = 0; i < 25; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(1, 0)));

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

- Bit-serial unsigned subtractor: computes `a - b - bin` one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- Counterpart to the team's combinational full-adder cells. It performs the reverse arithmetic (subtraction) and time-multiplexes one cell instead of replicating it.
- Sits beside the adder cells in the arithmetic datapath. Used where gate area matters more than latency.
- Start/busy/done handshake: a controller launches one operation at a time and reads the result when `done` pulses.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (WIDTH >= 1)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request to begin an operation; sampled only in IDLE or DONE
- a  input  WIDTH  minuend, latched when start is accepted
- b  input  WIDTH  subtrahend, latched when start is accepted
- bin  input  1  borrow-in, latched when start is accepted
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse: diff/bout valid
- diff  output  WIDTH  result (a - b - bin) mod 2^WIDTH
- bout  output  1  borrow-out: 1 iff a < b + bin (unsigned)

## Operation
States:
- IDLE: waits for a start.
- SHIFT: processes one bit per clock.
- DONE: presents the result for one cycle.

Transitions:
- IDLE, start=1: latch a, b and bin into internal shift registers; clear the bit counter and the result register; go to SHIFT. With start=0, stay in IDLE.
- SHIFT: each edge does the following.
  - d = a0 ^ b0 ^ br
  - br' = (~a0 & b0) | (~(a0 ^ b0) & br), where br is the borrow flip-flop (initialised from bin)
  - Shift d into the result register at the MSB.
  - Shift the operand registers right.
  - Increment the counter.
  - After the WIDTH-th bit is processed, go to DONE.
- DONE: lasts exactly one cycle.
  - With start=1 in this cycle, it is accepted exactly as in IDLE and the next state is SHIFT.
  - Otherwise the next state is IDLE.

Output rules:
- busy = 1 in SHIFT only.
- done = 1 in DONE only.
- diff and bout update only when DONE is entered. They hold that value until the next accepted start's DONE, or until reset.
- start is ignored in SHIFT.
- a, b and bin may change freely after acceptance without affecting the result.

Width rules:
- Counter width is $clog2(WIDTH+1).
- No signed interpretation; bout is the final borrow.

## Timing
- Reset (async): state=IDLE, busy=0, done=0, diff=0, bout=0, counter=0, borrow=0. Takes effect immediately, independent of clk.
- Reset mid-operation aborts the operation. The next start after release behaves normally.
- Start accepted at edge k:
  - busy is high in the WIDTH cycles following edges k .. k+WIDTH-1.
  - done is high in the cycle following edge k+WIDTH.
  - Latency from the accepting edge to done is WIDTH cycles.
- Back-to-back throughput: one result per WIDTH+1 cycles, with start held high or re-asserted in DONE.
- busy and done are never high simultaneously.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
All scenarios use WIDTH=8.
- Reset: assert rst asynchronously between edges → busy=0, done=0, diff=8'h00 and bout=0 immediately, with no clock edge needed.
- Basic: a=8'h3C, b=8'h1A, bin=0, pulse start → busy for 8 cycles, then done for exactly 1 cycle with diff=8'h22, bout=0. Values hold after done falls.
- Wrap-around / borrow:
  - a=8'h00, b=8'h01, bin=0 → diff=8'hFF, bout=1.
  - a=8'h55, b=8'h55, bin=1 → diff=8'hFF, bout=1.
  - a=8'hFF, b=8'h00, bin=1 → diff=8'hFE, bout=0.
- Ignored inputs:
  - start with a=8'h10, b=8'h01, bin=0.
  - In cycle 3, pulse start again and change a=8'hAA, b=8'hBB.
  - Expected: a single done 8 cycles after the first start, with diff=8'h0F, bout=0.
- Mid-op reset then recovery:
  - start a=8'h80, b=8'h01, bin=0; assert rst after the 4th bit → all outputs 0, state IDLE.
  - Release rst, then start a=8'h05, b=8'h07, bin=0 → diff=8'hFE, bout=1 after 8 cycles.
- Back-to-back: hold start=1 with a=8'h09, b=8'h04, bin=0, changing to a=8'h02, b=8'h03 during the first DONE cycle → two done pulses 9 cycles apart:
  - first: diff=8'h05, bout=0;
  - second: diff=8'hFF, bout=1.
